uart_json_rx: RTL and testbench
===============================

// Module: uart_json_rx
// PURPOSE
//  Receive end of the rover serial link: an 8N1 UART receiver on a GPIO pin feeding a
//  streaming parser that extracts signed decimal integers that follow ':' in JSON-style
//  lines (e.g. {"T":-120}\n) sent by the drive controller.
//  Output is a 16-bit value plus a valid strobe. The FSM / HEX logic consumes it as
//  telemetry/acknowledge.
//  Clocked on clk_50; sits beside the UART transmitter in the top level.
// PARAMETERS
//  CLK_FREQ    50_000_000  input clock frequency, Hz
//  BAUD        115200      line rate, bit/s
//  OVERSAMPLE  16          baud ticks per bit
//  MAX_DIGITS  5           max decimal digits accepted per number
// PORTS
//  clk          in   1   system clock (50 MHz)
//  rst_n        in   1   synchronous, active-low reset
//  rx           in   1   UART serial input, idle high (asynchronous to clk)
//  value        out  16  last parsed signed integer, two's complement
//  value_valid  out  1   1-cycle pulse: value updated this cycle
//  byte_valid   out  1   1-cycle pulse per correctly framed received byte
//  rx_byte      out  8   last received byte, valid while byte_valid=1
//  frame_err    out  1   1-cycle pulse: stop bit sampled low
//  ovf_err      out  1   1-cycle pulse: number exceeded MAX_DIGITS or 16-bit range
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0, both FSMs to IDLE/SEEK, accumulators 0.
//    Reset mid-byte abandons the byte; no pulses are emitted.
//  - rx passes a 2-FF synchroniser; the synchronised value resets to 1.
//  - Tick divider: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division (27 at default).
//    tick pulses once every DIV clocks.
//  - RX FSM:
//    - IDLE: a low level arms START and clears the tick count.
//    - START: after OVERSAMPLE/2 ticks, rx=0 -> DATA; rx=1 -> IDLE (glitch, no error).
//    - DATA: sample every OVERSAMPLE ticks, 8 bits, LSB first.
//    - STOP: sample after OVERSAMPLE ticks.
//      - rx=1: byte_valid=1, rx_byte=data.
//      - rx=0: frame_err=1 and the byte is discarded.
//      Either way -> IDLE. A start bit is re-armed only after rx is seen high.
//  - Parser (one byte per byte_valid, latency 1 clk from byte_valid to value_valid):
//    - SEEK: ':' -> SIGN; all other bytes ignored.
//    - SIGN: '-' sets neg -> DIGIT; '0'..'9' loads acc = d -> DIGIT; ' ' stays;
//      any other byte -> SEEK.
//    - DIGIT: '0'..'9' -> acc = acc*10 + d, ndig++.
//      - Any non-digit with ndig>=1 -> value = neg ? -acc : acc, value_valid=1.
//        Then -> SIGN if the byte is ':', otherwise -> SEEK.
//      - '-' followed directly by a non-digit emits nothing.
//    - Accumulator is 17 bits unsigned. Range limit: acc > 32767 (pos) or > 32768 (neg),
//      or ndig > MAX_DIGITS -> ovf_err=1, value unchanged, -> DISCARD.
//    - DISCARD: wait for ',', '}' or '\n' -> SEEK.
//    - '\n' or '{' in any state: end the current number (emit if valid), then -> SEEK.
//  - frame_err forces the parser to DISCARD (a corrupted number is never emitted).
//  - value holds between pulses. Simultaneous byte_valid/frame_err cannot occur.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1: an even-parity bit is sampled after bit 7, before the stop bit.
//    - Adds output parity_err (1 bit, 1-cycle pulse, reset 0) on mismatch.
//    - On mismatch the byte is discarded exactly as for frame_err.
//  UART_RX_PARITY_EN undefined: 8N1, no parity state, no parity_err port.
// STRUCTURE
//  - Package uart_json_pkg:
//    - rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP}
//    - parse_state_t {P_SEEK, P_SIGN, P_DIGIT, P_DISCARD}
//    - ASCII constants CH_COLON, CH_MINUS, CH_COMMA, CH_RBRACE, CH_LBRACE, CH_LF, CH_SPACE
//    - VALUE_MAX=32767, VALUE_MIN_MAG=32768
//  - Sub-module uart_rx_core: synchroniser, tick divider and RX FSM; outputs
//    byte_valid/rx_byte/frame_err(/parity_err).
//  - uart_json_rx instantiates it and holds the parser FSM.
// TESTING (defaults; 1 bit = 27*16 = 432 clks)
//  1 Reset held 10 clks with rx=0 -> all outputs 0; release with rx=1 -> no pulses.
//  2 Send "{\"T\":42}\n" -> 9 byte_valid pulses; value_valid once, value=16'd42,
//    1 clk after the '}' byte_valid.
//  3 Send ":-32768," then ":32767}" -> value=16'h8000, then value=16'h7FFF;
//    ":32768," -> ovf_err=1, value stays 16'h7FFF.
//  4 Send ":123456\n" -> ovf_err on the 6th digit, no value_valid.
//    Next ":7\n" -> value=7.
//  5 Drive stop bit low on byte '5' of ":15," -> frame_err=1, no value_valid;
//    a 100-clk low glitch on idle rx -> no byte_valid, no error.
//  6 UART_RX_PARITY_EN: ":9," with a correct parity bit -> value=9.
//    Bad parity on '9' -> parity_err=1, no value_valid.

Source files
------------

// File: rtl/uart_json_pkg.sv
// Shared types and constants for the rover serial-link receiver.
//   rx_state_t    : UART receive FSM states
//   parse_state_t : JSON number parser states
//   CH_*          : ASCII codes the parser reacts to
//   VALUE_MAX / VALUE_MIN_MAG : magnitude limits of a signed 16-bit result
package uart_json_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_SEEK,
        P_SIGN,
        P_DIGIT,
        P_DISCARD
    } parse_state_t;

    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_NINE   = 8'h39;

    localparam int unsigned VALUE_MAX     = 32767;
    localparam int unsigned VALUE_MIN_MAG = 32768;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_ZERO) && (c <= CH_NINE);
    endfunction

endpackage

// File: rtl/uart_json_rx_core.sv
// UART receive core: 2-FF synchroniser, oversampling tick divider and RX FSM.
// Optional macro UART_RX_PARITY_EN switches the frame from 8N1 to 8E1 and adds parity_err.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   byte_valid   1-cycle pulse per correctly framed byte
//   rx_byte      last good byte
//   frame_err    1-cycle pulse when the stop bit is sampled low
//   parity_err   1-cycle pulse on even-parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    import uart_json_pkg::*;

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    // Synchroniser; resets to the idle (high) line level.
    logic sync1_q, sync2_q;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Free-running oversample tick divider.
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Receive FSM.
    rx_state_t     state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          seen_high_q, seen_high_d;   // line seen idle since the last stop bit
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            seen_high_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            seen_high_q  <= seen_high_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        seen_high_d  = seen_high_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            RX_IDLE: begin
                if (rx_s) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A high level at mid-start is a glitch: drop it silently.
                        state_d    = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = RX_PARITY;
`else
                            state_d = RX_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        // Even parity: data ones plus parity bit must be even.
                        par_bad_d  = rx_s ^ (^shift_q);
                        state_d    = RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`else
                state_d = RX_IDLE;
`endif
            end
            RX_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d  = '0;
                        state_d     = RX_IDLE;
                        seen_high_d = 1'b0;
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
`endif
                        end else begin
                            byte_valid_d = 1'b1;
                            rx_byte_d    = shift_q;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: rtl/uart_json_rx.sv
// Rover serial-link receiver: UART core plus a streaming parser that extracts signed
// decimal integers following ':' in JSON-style lines such as {"T":-120}\n.
// Optional macro UART_RX_PARITY_EN selects 8E1 framing and adds the parity_err port.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   value        last parsed signed integer (two's complement), holds between pulses
//   value_valid  1-cycle pulse, value updated this cycle
//   byte_valid   1-cycle pulse per correctly framed byte; rx_byte holds the byte
//   frame_err    1-cycle pulse, stop bit low
//   ovf_err      1-cycle pulse, number too long or out of 16-bit signed range
//   parity_err   1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_json_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        byte_valid,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        ovf_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic        parity_err
`endif
);
    import uart_json_pkg::*;

    localparam int unsigned NW = $clog2(MAX_DIGITS + 2);

    logic rx_err;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

`ifdef UART_RX_PARITY_EN
    assign rx_err = frame_err | parity_err;
`else
    assign rx_err = frame_err;
`endif

    parse_state_t  p_q, p_d;
    logic          neg_q, neg_d;
    logic [16:0]   acc_q, acc_d;
    logic [NW-1:0] ndig_q, ndig_d;
    logic [15:0]   value_q, value_d;
    logic          value_valid_q, value_valid_d;
    logic          ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q           <= P_SEEK;
            neg_q         <= 1'b0;
            acc_q         <= '0;
            ndig_q        <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            p_q           <= p_d;
            neg_q         <= neg_d;
            acc_q         <= acc_d;
            ndig_q        <= ndig_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    // Candidate accumulator with headroom so the range check sees the true magnitude.
    logic [19:0]   acc_next;
    logic [19:0]   limit;
    logic [NW-1:0] ndig_inc;
    logic [15:0]   signed_val;
    logic          have_num;

    assign acc_next   = 20'(acc_q) * 20'd10 + 20'(rx_byte[3:0]);
    assign limit      = neg_q ? 20'(VALUE_MIN_MAG) : 20'(VALUE_MAX);
    assign ndig_inc   = ndig_q + NW'(1);
    // -32768 has magnitude 0x8000 whose 16-bit negation is itself.
    assign signed_val = neg_q ? (~acc_q[15:0] + 16'd1) : acc_q[15:0];
    assign have_num   = (p_q == P_DIGIT) && (ndig_q != '0);

    always_comb begin
        p_d           = p_q;
        neg_d         = neg_q;
        acc_d         = acc_q;
        ndig_d        = ndig_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        ovf_d         = 1'b0;

        if (rx_err) begin
            p_d = P_DISCARD;
        end else if (byte_valid) begin
            if ((rx_byte == CH_LF) || (rx_byte == CH_LBRACE)) begin
                if (have_num) begin
                    value_d       = signed_val;
                    value_valid_d = 1'b1;
                end
                p_d = P_SEEK;
            end else begin
                unique case (p_q)
                    P_SEEK: begin
                        if (rx_byte == CH_COLON) begin
                            p_d    = P_SIGN;
                            neg_d  = 1'b0;
                            acc_d  = '0;
                            ndig_d = '0;
                        end
                    end
                    P_SIGN: begin
                        if (rx_byte == CH_MINUS) begin
                            neg_d = 1'b1;
                            p_d   = P_DIGIT;
                        end else if (is_digit(rx_byte)) begin
                            acc_d  = 17'(rx_byte[3:0]);
                            ndig_d = NW'(1);
                            p_d    = P_DIGIT;
                        end else if (rx_byte != CH_SPACE) begin
                            p_d = P_SEEK;
                        end
                    end
                    P_DIGIT: begin
                        if (is_digit(rx_byte)) begin
                            if ((ndig_inc > NW'(MAX_DIGITS)) || (acc_next > limit)) begin
                                ovf_d = 1'b1;
                                p_d   = P_DISCARD;
                            end else begin
                                acc_d  = acc_next[16:0];
                                ndig_d = ndig_inc;
                            end
                        end else begin
                            if (have_num) begin
                                value_d       = signed_val;
                                value_valid_d = 1'b1;
                            end
                            if (rx_byte == CH_COLON) begin
                                p_d    = P_SIGN;
                                neg_d  = 1'b0;
                                acc_d  = '0;
                                ndig_d = '0;
                            end else begin
                                p_d = P_SEEK;
                            end
                        end
                    end
                    P_DISCARD: begin
                        if ((rx_byte == CH_COMMA) || (rx_byte == CH_RBRACE)) begin
                            p_d = P_SEEK;
                        end
                    end
                    default: p_d = P_SEEK;
                endcase
            end
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_uart_json_rx.sv
// Bench for uart_json_rx. The line rate is raised (2 clocks per oversample tick) to keep
// simulation short; the frame format and parser behaviour are unchanged.
module tb_uart_json_rx;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 1_562_500;
    localparam int unsigned OS       = 16;
    localparam int          BIT      = (CLK_FREQ / (BAUD * OS)) * OS;  // clocks per bit

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] value;
    logic        value_valid;
    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        frame_err;
    logic        ovf_err;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    uart_json_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS),
        .MAX_DIGITS(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .value      (value),
        .value_valid(value_valid),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .ovf_err    (ovf_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event monitor (sampled on the falling edge).
    int cyc = 0;
    int n_bytes = 0, n_vv = 0, n_ovf = 0, n_ferr = 0, n_perr = 0;
    int rbrace_cyc = 0, vv_cyc = 0;
    logic [15:0] got_vals[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bytes++;
            if (rx_byte == 8'h7D) rbrace_cyc = cyc;
        end
        if (value_valid) begin
            n_vv++;
            vv_cyc = cyc;
            got_vals.push_back(value);
        end
        if (ovf_err) n_ovf++;
        if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
    end

    int b0, v0, o0, f0, p0;

    task automatic snap();
        b0 = n_bytes; v0 = n_vv; o0 = n_ovf; f0 = n_ferr; p0 = n_perr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        repeat (BIT) @(negedge clk);
`endif
        rx = ~bad_stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (bad_stop ? BIT : 2) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int bad_stop_idx, input int bad_par_idx);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], i == bad_stop_idx, i == bad_par_idx);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_vals[$];
        int          exp_ovf;
        string       s;

        // Reset with the line held low.
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_value_valid", 32'(value_valid), 32'h0);
        chk("rst_byte_valid", 32'(byte_valid), 32'h0);
        chk("rst_rx_byte", 32'(rx_byte), 32'h0);
        chk("rst_errs", 32'({frame_err, ovf_err}), 32'h0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_pulses", 32'(n_bytes + n_vv + n_ovf + n_ferr + n_perr), 32'h0);

        // Basic record, latency from the '}' byte to value_valid.
        snap();
        send_str("{\"T\":42}\n", -1, -1);
        chk("t2_bytes", 32'(n_bytes - b0), 32'd9);
        chk("t2_vv", 32'(n_vv - v0), 32'd1);
        chk("t2_value", 32'(value), 32'd42);
        chk("t2_latency", 32'(vv_cyc - rbrace_cyc), 32'd1);

        // Range limits.
        snap();
        send_str(":-32768,", -1, -1);
        chk("t3_min", 32'(value), 32'h8000);
        send_str(":32767}", -1, -1);
        chk("t3_max", 32'(value), 32'h7FFF);
        chk("t3_vv", 32'(n_vv - v0), 32'd2);
        snap();
        send_str(":32768,", -1, -1);
        chk("t3_ovf", 32'(n_ovf - o0), 32'd1);
        chk("t3_ovf_vv", 32'(n_vv - v0), 32'd0);
        chk("t3_hold", 32'(value), 32'h7FFF);

        // Too many digits, then recovery.
        snap();
        send_str(":123456\n", -1, -1);
        chk("t4_ovf", 32'(n_ovf - o0), 32'd1);
        chk("t4_vv", 32'(n_vv - v0), 32'd0);
        send_str(":7\n", -1, -1);
        chk("t4_value", 32'(value), 32'd7);

        // Framing error on the '5' of ":15,".
        snap();
        send_str(":15,", 2, -1);
        chk("t5_ferr", 32'(n_ferr - f0), 32'd1);
        chk("t5_vv", 32'(n_vv - v0), 32'd0);
        chk("t5_bytes", 32'(n_bytes - b0), 32'd3);

        // Short low glitch on the idle line (under half a bit).
        snap();
        rx = 1'b0;
        repeat (BIT / 3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_bytes", 32'(n_bytes - b0), 32'd0);
        chk("glitch_err", 32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_str(":9,", -1, -1);
        chk("t6_value", 32'(value), 32'd9);
        snap();
        send_str(":8,", -1, 1);
        chk("t6_perr", 32'(n_perr - p0), 32'd1);
        chk("t6_vv", 32'(n_vv - v0), 32'd0);
        chk("t6_hold", 32'(value), 32'd9);
`endif

        // Random records; expectations follow from how each number was generated.
        for (int r = 0; r < 4; r++) begin
            int nf;
            exp_vals.delete();
            exp_ovf = 0;
            nf = int'($urandom_range(1, 2));
            s  = "{";
            for (int f = 0; f < nf; f++) begin
                int v;
                s = {s, $sformatf("\"k%0d\":", f)};
                if ($urandom_range(0, 1) == 1) s = {s, " "};
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) v = int'($urandom_range(32768, 199999));
                    else v = -int'($urandom_range(32769, 199999));
                    exp_ovf++;
                end else begin
                    v = int'($urandom_range(0, 65535)) - 32768;
                    exp_vals.push_back(16'(v));
                end
                s = {s, $sformatf("%0d", v), (f == nf - 1) ? "}" : ","};
            end
            s = {s, "\n"};
            snap();
            send_str(s, -1, -1);
            chk($sformatf("rnd%0d_bytes", r), 32'(n_bytes - b0), 32'(s.len()));
            chk($sformatf("rnd%0d_vv", r), 32'(n_vv - v0), 32'(exp_vals.size()));
            chk($sformatf("rnd%0d_ovf", r), 32'(n_ovf - o0), 32'(exp_ovf));
            for (int i = 0; i < exp_vals.size(); i++) begin
                if (v0 + i < got_vals.size()) begin
                    chk($sformatf("rnd%0d_val%0d", r, i), 32'(got_vals[v0 + i]),
                        32'(exp_vals[i]));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
